// File: rtl/pixel_fetch_sequencer.sv
// Frame-buffer fetch controller: walks base..base+count-1 over a four-phase
// req/rdy memory channel and queues each word for a valid/ready pixel consumer.
module pixel_fetch_sequencer #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int FIFO_AW       = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [ADDRESS_WIDTH-1:0] pixel_count,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     data_req,
   output logic [ADDRESS_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0]    data,
   input  logic                     data_rdy,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    out_data,
   input  logic                     out_ready
);

   typedef enum logic [1:0] {IDLE, WAIT_SPACE, REQ, RELEASE} state_t;

   localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] base_q;
   logic [ADDRESS_WIDTH-1:0] count_q;
   logic [ADDRESS_WIDTH-1:0] index_q;
   logic [ADDRESS_WIDTH-1:0] index_next;

   logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]       wr_ptr;
   logic [FIFO_AW-1:0]       rd_ptr;
   logic [FIFO_AW-1:0]       rd_next;
   logic [FIFO_AW:0]         fifo_count;
   logic [FIFO_AW:0]         occ_after_pop;
   logic                     push;
   logic                     pop;

   // Occupancy seen by WAIT_SPACE already accounts for a pop in the same cycle.
   assign pop           = out_ready && (fifo_count != '0);
   assign push          = (state == REQ) && data_rdy;
   assign occ_after_pop = fifo_count - (FIFO_AW+1)'(pop);
   assign rd_next       = rd_ptr + FIFO_AW'(pop);
   assign index_next    = index_q + ADDRESS_WIDTH'(1);
   assign out_valid     = (fifo_count != '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         data_req   <= 1'b0;
         data_addr  <= '0;
         base_q     <= '0;
         count_q    <= '0;
         index_q    <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  base_q  <= base_addr;
                  count_q <= pixel_count;
                  index_q <= '0;
                  if (pixel_count == '0) begin
                     frame_done <= 1'b1;
                  end else begin
                     busy  <= 1'b1;
                     state <= WAIT_SPACE;
                  end
               end
            end
            WAIT_SPACE: begin
               if (occ_after_pop < DEPTH_L) begin
                  data_req  <= 1'b1;
                  data_addr <= base_q + index_q;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (data_rdy) begin
                  data_req <= 1'b0;
                  state    <= RELEASE;
               end
            end
            RELEASE: begin
               // A stale rdy must clear before the next request may rise.
               if (!data_rdy) begin
                  index_q <= index_next;
                  if (index_next == count_q) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     state <= WAIT_SPACE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         out_data   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         rd_ptr     <= rd_next;
         fifo_count <= occ_after_pop + (FIFO_AW+1)'(push);
         // Head register follows the word that will be at rd_ptr next cycle.
         if (push && (occ_after_pop == '0)) out_data <= data;
         else if (pop)                      out_data <= mem[rd_next];
      end
   end

   // NOTE: storage has no reset; the pointers and count alone define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data;
   end

endmodule
